// File: rtl/exu_mdv_pkg.sv
// Shared widths, op codes and state encodings for the iterative multiply/divide unit.
package exu_mdv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned PW          = 2 * XLEN;
    localparam int unsigned RFIDX_WIDTH = 5;
    localparam int unsigned CNT_W       = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        MDV_OP_MUL    = 3'd0,
        MDV_OP_MULH   = 3'd1,
        MDV_OP_MULHSU = 3'd2,
        MDV_OP_MULHU  = 3'd3,
        MDV_OP_DIV    = 3'd4,
        MDV_OP_DIVU   = 3'd5,
        MDV_OP_REM    = 3'd6,
        MDV_OP_REMU   = 3'd7
    } mdv_op_e;

    typedef enum logic [1:0] {
        MDV_ST_IDLE = 2'd0,
        MDV_ST_MUL  = 2'd1,
        MDV_ST_DIV  = 2'd2,
        MDV_ST_DONE = 2'd3
    } mdv_state_e;

endpackage

// File: rtl/exu_mdv_if.sv
// Request and write-back channels of the multiply/divide unit.
interface exu_mdv_if;
    import exu_mdv_pkg::*;

    logic                   mdv_i_valid;
    logic                   mdv_i_ready;
    mdv_op_e                mdv_i_op;
    logic [XLEN-1:0]        mdv_i_rs1;
    logic [XLEN-1:0]        mdv_i_rs2;
    logic [RFIDX_WIDTH-1:0] mdv_i_rdidx;
    logic                   mdv_wbck_o_valid;
    logic                   mdv_wbck_o_ready;
    logic [XLEN-1:0]        mdv_wbck_o_wdat;
    logic [RFIDX_WIDTH-1:0] mdv_wbck_o_rdidx;

    modport master (
        output mdv_i_valid, mdv_i_op, mdv_i_rs1, mdv_i_rs2, mdv_i_rdidx, mdv_wbck_o_ready,
        input  mdv_i_ready, mdv_wbck_o_valid, mdv_wbck_o_wdat, mdv_wbck_o_rdidx
    );

    modport slave (
        input  mdv_i_valid, mdv_i_op, mdv_i_rs1, mdv_i_rs2, mdv_i_rdidx, mdv_wbck_o_ready,
        output mdv_i_ready, mdv_wbck_o_valid, mdv_wbck_o_wdat, mdv_wbck_o_rdidx
    );

endinterface

// File: rtl/exu_mdv.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, result held on a valid/ready write-back port.
module exu_mdv
    import exu_mdv_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    exu_mdv_if.slave mdv
);

    mdv_state_e             state_q, state_d;
    mdv_op_e                op_q, op_d;
    logic [RFIDX_WIDTH-1:0] rd_q, rd_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic [XLEN-1:0]        opb_q, opb_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   neg_q, neg_d;
    logic [XLEN-1:0]        wdat_q, wdat_d;
    logic                   valid_q, ready_q;

    logic                   s1, s2, last_iter;
    logic [XLEN:0]          mul_sum, div_sh, div_diff;
    logic [PW-1:0]          prod;
    logic [XLEN-1:0]        sel;

    function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] a);
        return (~a) + XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] abs_f(input logic [XLEN-1:0] a, input logic sgn);
        return (sgn && a[XLEN-1]) ? neg_f(a) : a;
    endfunction

    assign s1        = mdv.mdv_i_rs1[XLEN-1];
    assign s2        = mdv.mdv_i_rs2[XLEN-1];
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    // Datapath step: high half of acc is the partial product / partial remainder.
    assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[PW-1:XLEN]} + {1'b0, opb_q})
                               : {1'b0, acc_q[PW-1:XLEN]};
    assign div_sh   = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opb_q};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        wdat_d  = wdat_q;
        prod    = '0;
        sel     = '0;

        unique case (state_q)
            MDV_ST_IDLE: begin
                if (mdv.mdv_i_valid) begin
                    op_d  = mdv.mdv_i_op;
                    rd_d  = mdv.mdv_i_rdidx;
                    cnt_d = '0;
                    unique case (mdv.mdv_i_op)
                        MDV_OP_MUL, MDV_OP_MULHU: begin
                            opb_d = mdv.mdv_i_rs1;
                            acc_d = {XLEN'(0), mdv.mdv_i_rs2};
                            neg_d = 1'b0;
                        end
                        MDV_OP_MULH: begin
                            opb_d = abs_f(mdv.mdv_i_rs1, 1'b1);
                            acc_d = {XLEN'(0), abs_f(mdv.mdv_i_rs2, 1'b1)};
                            neg_d = s1 ^ s2;
                        end
                        MDV_OP_MULHSU: begin
                            opb_d = abs_f(mdv.mdv_i_rs1, 1'b1);
                            acc_d = {XLEN'(0), mdv.mdv_i_rs2};
                            neg_d = s1;
                        end
                        default: begin
                            opb_d = abs_f(mdv.mdv_i_rs2, !mdv.mdv_i_op[0]);
                            acc_d = {XLEN'(0), abs_f(mdv.mdv_i_rs1, !mdv.mdv_i_op[0])};
                            neg_d = !mdv.mdv_i_op[0] && (mdv.mdv_i_op[1] ? s1 : (s1 ^ s2));
                        end
                    endcase
                    if (!mdv.mdv_i_op[2]) begin
                        state_d = MDV_ST_MUL;
                    end else if (mdv.mdv_i_rs2 == '0) begin
                        wdat_d  = mdv.mdv_i_op[1] ? mdv.mdv_i_rs1 : '1;
                        state_d = MDV_ST_DONE;
                    end else if (!mdv.mdv_i_op[0] && (mdv.mdv_i_rs1 == {1'b1, (XLEN-1)'(0)})
                                 && (mdv.mdv_i_rs2 == '1)) begin
                        wdat_d  = mdv.mdv_i_op[1] ? '0 : mdv.mdv_i_rs1;
                        state_d = MDV_ST_DONE;
                    end else begin
                        state_d = MDV_ST_DIV;
                    end
                end
            end
            MDV_ST_MUL: begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    prod    = neg_q ? ((~acc_d) + PW'(1)) : acc_d;
                    wdat_d  = (op_q == MDV_OP_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
                    state_d = MDV_ST_DONE;
                end
            end
            MDV_ST_DIV: begin
                acc_d = {div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0],
                         acc_q[XLEN-2:0], !div_diff[XLEN]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    sel     = op_q[1] ? acc_d[PW-1:XLEN] : acc_d[XLEN-1:0];
                    wdat_d  = neg_q ? neg_f(sel) : sel;
                    state_d = MDV_ST_DONE;
                end
            end
            MDV_ST_DONE: begin
                if (mdv.mdv_wbck_o_ready) begin
                    state_d = MDV_ST_IDLE;
                end
            end
            default: state_d = MDV_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDV_ST_IDLE;
            op_q    <= MDV_OP_MUL;
            rd_q    <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            wdat_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            wdat_q  <= wdat_d;
            valid_q <= (state_d == MDV_ST_DONE);
            ready_q <= (state_d == MDV_ST_IDLE);
        end
    end

    assign mdv.mdv_i_ready      = ready_q;
    assign mdv.mdv_wbck_o_valid = valid_q;
    assign mdv.mdv_wbck_o_wdat  = wdat_q;
    assign mdv.mdv_wbck_o_rdidx = rd_q;

endmodule

// File: doc/exu_mdv.md
# exu_mdv

Iterative multiply/divide unit for the RV M-extension, placed in the execute stage directly upstream of `exu_wbck`. It accepts one M-type operation at a time from the dispatch path. It computes the result over XLEN cycles using a radix-2 shift-add multiplier or a restoring divider. It then presents the result on a valid/ready write-back port that drives the `alu_wbck_i_*` inputs of `exu_wbck`.

## Interface
- `XLEN`, from `defines.v`: operand and result width (32 or 64).
- `RFIDX_WIDTH`, from `defines.v`: destination register index width.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mdv_i_valid` input 1: operation request.
- `mdv_i_ready` output 1: unit can accept; equals (state == IDLE).
- `mdv_i_op` input 3: funct3 code. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `mdv_i_rs1` input XLEN: operand 1 (multiplicand / dividend).
- `mdv_i_rs2` input XLEN: operand 2 (multiplier / divisor).
- `mdv_i_rdidx` input RFIDX_WIDTH: destination register.
- `mdv_wbck_o_valid` output 1: result available.
- `mdv_wbck_o_ready` input 1: write-back accepts.
- `mdv_wbck_o_wdat` output XLEN: result.
- `mdv_wbck_o_rdidx` output RFIDX_WIDTH: destination register of the result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - On `mdv_i_valid`, capture op, rdidx and operands. Operands are converted to magnitudes where the op is signed (MULH: both; MULHSU: rs1 only; DIV/REM: both). The result sign is recorded.
  - Next state: MUL for ops 0–3. For ops 4–7: DIV, unless a special case applies, which goes directly to DONE.
- Special cases (no iteration):
  - Divisor zero: quotient = all ones, remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1, DIV/REM only): quotient = rs1, remainder = 0.
- MUL: 2·XLEN-bit accumulator. Each cycle, add the multiplicand if the current multiplier bit is 1, then shift. Runs XLEN iterations, then goes to DONE.
- DIV: restoring division on magnitudes, one quotient bit per cycle. Runs XLEN iterations, then goes to DONE.
- Iteration counter width is $clog2(XLEN)+1. It is loaded with 0 on accept and increments each iteration cycle. The exit condition is count == XLEN−1 on the last iteration.
- DONE:
  - `mdv_wbck_o_valid` = 1.
  - wdat is the low half (MUL) or the high half (MULH*) of the sign-corrected product, or the sign-corrected quotient or remainder.
  - Remainder takes the sign of the dividend. Quotient is negated when the operand signs differ.
  - On `mdv_wbck_o_ready`, go to IDLE. Otherwise hold DONE with wdat/rdidx stable.
- No new op is accepted in the cycle the result is consumed; `mdv_i_ready` rises one cycle later.
- Arithmetic is modulo 2^XLEN, or 2^(2·XLEN) for the product.

## Timing
- Reset (async assert, any state) forces:
  - state IDLE
  - `mdv_i_ready` = 1
  - `mdv_wbck_o_valid` = 0
  - `mdv_wbck_o_wdat` = 0
  - `mdv_wbck_o_rdidx` = 0
- An in-flight operation is discarded on reset and never produces a write-back.
- Accept in cycle T (`mdv_i_valid` & `mdv_i_ready`):
  - MUL/DIV iterations occupy T+1 … T+XLEN.
  - Valid is asserted in cycle T+XLEN+1.
  - Special-case divides are valid in T+1.
- With `mdv_wbck_o_ready` tied high, the result is held for exactly one cycle and `mdv_i_ready` = 1 at T+XLEN+2.
- Backpressure: valid stays high and wdat/rdidx stay constant until ready is sampled high.
- Inputs are ignored while `mdv_i_ready` = 0; the requester must hold valid until accepted.
- Output `wdat` may be combinational from internal registers, but must be glitch-free relative to `clk` sampling. No input-to-output combinational path.

## Structure
- Add to `defines.v`: `MDV_OP_MUL` … `MDV_OP_REMU` (3-bit codes above) and the state encodings `MDV_ST_IDLE/MUL/DIV/DONE`.
- Single module. Abs/negate helpers are local functions; no sub-module is warranted.
- Top-level glue connects `mdv_wbck_o_*` to `exu_wbck` `alu_wbck_i_*`.

## Test plan
- XLEN=32, MUL rs1=7, rs2=−3, rd=5 → valid at T+33, wdat=0xFFFFFFEB, rdidx=5, one-cycle valid, ready high at T+34.
- MULH 0x80000000 × 0x80000000 → wdat=0x40000000. MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14 and REMU 100/7 → 2.
- DIV by 0 → 0xFFFFFFFF at T+1. REM 5 by 0 → 5. DIV 0x80000000 by −1 → 0x80000000, REM → 0; both at T+1.
- Hold `mdv_wbck_o_ready` low 4 cycles at DONE → valid/wdat/rdidx stable, `mdv_i_ready`=0, new requests not accepted. Release → one-cycle handshake, then IDLE.
- Assert `rst_n` low mid-DIV (iteration 10) → all outputs reset immediately, no valid after release, next op completes correctly.
